// File: rtl/urv_dm_arbiter_pkg.sv
// Shared types for the dm-port RAM arbiter:
// FSM states, master ids, RAM window decode helper.
package urv_dm_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam logic M_CPU = 1'b0;
   localparam logic M_DBG = 1'b1;

   // Unsigned offset from the window base; anything at or
   // beyond 4*2^aw bytes is outside the RAM.
   function automatic logic out_of_win(
      input logic [31:0] addr,
      input logic [31:0] base,
      input int unsigned aw
   );
      logic [31:0] off;
      off = addr - base;
      return (off >> (aw + 2)) != 32'd0;
   endfunction

endpackage

// File: rtl/urv_dm_arbiter_if.sv
// One dm-style requester port (cpu data port or loader).
// master: requester side, slave: arbiter side.
interface urv_dm_if;

   logic [31:0] addr;
   logic [31:0] data_s;
   logic [3:0]  select;
   logic        store;
   logic        load;
   logic [31:0] data_l;
   logic        load_done;
   logic        store_done;
   logic        ready;

   modport master (
      output addr, data_s, select, store, load,
      input  data_l, load_done, store_done, ready
   );

   modport slave (
      input  addr, data_s, select, store, load,
      output data_l, load_done, store_done, ready
   );

endinterface

// File: rtl/urv_dm_arbiter_rr_arb2.sv
// Two-way picker: round-robin (rr_i=1) or M0-first.
// Ports: req_i requests, adv_i grant taken, win_o/vld_o pick.
module urv_rr_arb2
   import urv_dm_arbiter_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rr_i,
   input  logic [1:0] req_i,
   input  logic       adv_i,
   output logic       vld_o,
   output logic       win_o
);

   // Last granted master; reset value makes M0 win first.
   logic last_q;

   always_comb begin
      vld_o = |req_i;
      win_o = M_CPU;
      case (req_i)
         2'b01:   win_o = M_CPU;
         2'b10:   win_o = M_DBG;
         2'b11:   win_o = (rr_i && last_q == M_CPU) ? M_DBG : M_CPU;
         default: win_o = M_CPU;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         last_q <= M_DBG;
      else if (adv_i && vld_o)
         last_q <= win_o;
   end

endmodule

// File: rtl/urv_dm_arbiter.sv
// Shares a 1-cycle-latency single-port RAM between M0 (cpu) and M1 (loader).
// Ports: clk_i/rst_i, m0/m1 dm ports, mem_* RAM side, err_o sticky window error.
module urv_dm_arbiter
   import urv_dm_arbiter_pkg::*;
#(
   parameter int unsigned AW        = 12,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter bit          RR        = 1'b1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   urv_dm_if.slave       m0,
   urv_dm_if.slave       m1,
   output logic          mem_en_o,
   output logic          mem_we_o,
   output logic [3:0]    mem_be_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [31:0]   mem_wdata_o,
   input  logic [31:0]   mem_rdata_i,
   output logic          err_o
);

   state_t state_q, state_d;

   logic [AW-1:0] addr_q;
   logic [31:0]   data_q;
   logic [3:0]    sel_q;
   logic          we_q;
   logic          id_q;
   logic          oow_q;
   logic          err_q;

   logic [1:0]  req;
   logic        win, vld, grant;
   logic [31:0] w_addr, w_data;
   logic [3:0]  w_sel;
   logic        w_we;
   logic        idle, acc, rsp;
   logic [31:0] rdata;

   assign req = {m1.store | m1.load, m0.store | m0.load};

   urv_rr_arb2 u_arb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .rr_i  (RR),
      .req_i (req),
      .adv_i (idle),
      .vld_o (vld),
      .win_o (win)
   );

   // Store wins over load when both are raised by one master.
   assign w_addr = win ? m1.addr   : m0.addr;
   assign w_data = win ? m1.data_s : m0.data_s;
   assign w_sel  = win ? m1.select : m0.select;
   assign w_we   = win ? m1.store  : m0.store;

   assign idle  = state_q == ST_IDLE;
   assign acc   = state_q == ST_ACCESS;
   assign rsp   = state_q == ST_RESP;
   assign grant = idle && vld;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (vld) state_d = ST_ACCESS;
         ST_ACCESS: state_d = we_q ? ST_IDLE : ST_RESP;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         sel_q   <= '0;
         we_q    <= 1'b0;
         id_q    <= M_CPU;
         oow_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            addr_q <= w_addr[AW+1:2];
            data_q <= w_data;
            sel_q  <= w_sel;
            we_q   <= w_we;
            id_q   <= win;
            oow_q  <= out_of_win(w_addr, BASE_ADDR, AW);
            if (out_of_win(w_addr, BASE_ADDR, AW))
               err_q <= 1'b1;
         end
      end
   end

   // Outside the window the FSM still walks ACCESS/RESP, RAM untouched.
   assign mem_en_o    = acc && !oow_q;
   assign mem_we_o    = mem_en_o && we_q;
   assign mem_be_o    = mem_en_o ? (we_q ? sel_q : 4'hF) : 4'h0;
   assign mem_addr_o  = mem_en_o ? addr_q : '0;
   assign mem_wdata_o = mem_we_o ? data_q : 32'h0;
   assign err_o       = err_q;

   assign rdata = oow_q ? 32'h0 : mem_rdata_i;

   assign m0.store_done = acc && we_q && id_q == M_CPU;
   assign m1.store_done = acc && we_q && id_q == M_DBG;
   assign m0.load_done  = rsp && id_q == M_CPU;
   assign m1.load_done  = rsp && id_q == M_DBG;
   assign m0.data_l     = m0.load_done ? rdata : 32'h0;
   assign m1.data_l     = m1.load_done ? rdata : 32'h0;
   assign m0.ready      = idle && !rst_i;
   assign m1.ready      = idle && !rst_i;

endmodule

// File: tb/tb_urv_dm_arbiter.sv
// Directed bench for urv_dm_arbiter: RR instance with RAM model,
// plus a fixed-priority instance for the tie-break case.
module tb_urv_dm_arbiter;

   localparam int AW = 12;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;

   always #5 clk_i = ~clk_i;

   urv_dm_if m0_if ();
   urv_dm_if m1_if ();
   urv_dm_if f0_if ();
   urv_dm_if f1_if ();

   logic          mem_en, mem_we;
   logic [3:0]    mem_be;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata, mem_rdata;
   logic          err;

   logic          f_en, f_we;
   logic [3:0]    f_be;
   logic [AW-1:0] f_addr;
   logic [31:0]   f_wdata;
   logic          f_err;

   urv_dm_arbiter #(.AW(AW), .BASE_ADDR(32'h0), .RR(1'b1)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .m0          (m0_if),
      .m1          (m1_if),
      .mem_en_o    (mem_en),
      .mem_we_o    (mem_we),
      .mem_be_o    (mem_be),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata),
      .err_o       (err)
   );

   urv_dm_arbiter #(.AW(AW), .BASE_ADDR(32'h0), .RR(1'b0)) dut_fp (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .m0          (f0_if),
      .m1          (f1_if),
      .mem_en_o    (f_en),
      .mem_we_o    (f_we),
      .mem_be_o    (f_be),
      .mem_addr_o  (f_addr),
      .mem_wdata_o (f_wdata),
      .mem_rdata_i (32'h0),
      .err_o       (f_err)
   );

   logic [31:0] ram [0:(1<<AW)-1] = '{default: 32'h0};
   logic [31:0] rdata_q = 32'h0;

   always @(posedge clk_i) begin
      if (mem_en) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_be[b])
                  ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end else begin
            rdata_q <= ram[mem_addr];
         end
      end
   end

   assign mem_rdata = rdata_q;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h want %h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic idle_ports();
      m0_if.addr = 0; m0_if.data_s = 0; m0_if.select = 0;
      m0_if.store = 0; m0_if.load = 0;
      m1_if.addr = 0; m1_if.data_s = 0; m1_if.select = 0;
      m1_if.store = 0; m1_if.load = 0;
      f0_if.addr = 0; f0_if.data_s = 0; f0_if.select = 0;
      f0_if.store = 0; f0_if.load = 0;
      f1_if.addr = 0; f1_if.data_s = 0; f1_if.select = 0;
      f1_if.store = 0; f1_if.load = 0;
   endtask

   int seq [$];
   int f0_cnt, f1_cnt;

   initial begin
      idle_ports();
      @(negedge clk_i);
      repeat (3) step();
      chk("rst_en",   {31'b0, mem_en}, 32'h0);
      chk("rst_err",  {31'b0, err}, 32'h0);
      chk("rst_addr", {20'b0, mem_addr}, 32'h0);
      chk("rst_rdy",  {31'b0, m0_if.ready}, 32'h0);
      rst_i = 1'b0;
      step();
      chk("rdy_idle", {31'b0, m0_if.ready}, 32'h1);

      // reset in the middle of a load
      m0_if.addr = 32'h100; m0_if.load = 1'b1;
      step();
      chk("ml_en", {31'b0, mem_en}, 32'h1);
      rst_i = 1'b1;
      step();
      chk("ml_en0", {31'b0, mem_en}, 32'h0);
      chk("ml_ld0", {31'b0, m0_if.load_done}, 32'h0);
      m0_if.load = 1'b0;
      step();
      chk("ml_ld1", {31'b0, m0_if.load_done}, 32'h0);
      step();
      rst_i = 1'b0;
      step();
      chk("ml_en1", {31'b0, mem_en}, 32'h0);

      // M0 partial store
      m0_if.addr = 32'h100; m0_if.data_s = 32'hA5A5_1234;
      m0_if.select = 4'b0011; m0_if.store = 1'b1;
      step();
      chk("st_en",   {31'b0, mem_en}, 32'h1);
      chk("st_we",   {31'b0, mem_we}, 32'h1);
      chk("st_addr", {20'b0, mem_addr}, 32'h040);
      chk("st_be",   {28'b0, mem_be}, 32'h3);
      chk("st_wd",   mem_wdata, 32'hA5A5_1234);
      chk("st_done", {31'b0, m0_if.store_done}, 32'h1);
      chk("st_rdy1", {31'b0, m1_if.ready}, 32'h0);
      m0_if.store = 1'b0;
      step();
      chk("st_done0", {31'b0, m0_if.store_done}, 32'h0);
      chk("ram_part", ram[12'h040], 32'h0000_1234);

      // full-word store then M1 load of it
      m0_if.data_s = 32'hCAFE_BABE; m0_if.select = 4'hF;
      m0_if.store = 1'b1;
      step();
      m0_if.store = 1'b0;
      step();
      m1_if.addr = 32'h100; m1_if.load = 1'b1;
      step();
      chk("ld_acc_we", {31'b0, mem_we}, 32'h0);
      chk("ld_acc_be", {28'b0, mem_be}, 32'hF);
      chk("ld_early",  {31'b0, m1_if.load_done}, 32'h0);
      step();
      chk("ld_done", {31'b0, m1_if.load_done}, 32'h1);
      chk("ld_data", m1_if.data_l, 32'hCAFE_BABE);
      m1_if.load = 1'b0;
      step();

      // both masters load continuously
      m0_if.addr = 32'h100; m0_if.load = 1'b1;
      m1_if.addr = 32'h100; m1_if.load = 1'b1;
      f0_if.addr = 32'h100; f0_if.load = 1'b1;
      f1_if.addr = 32'h100; f1_if.load = 1'b1;
      f0_cnt = 0; f1_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (m0_if.load_done) seq.push_back(0);
         if (m1_if.load_done) seq.push_back(1);
         if (f0_if.load_done) f0_cnt++;
         if (f1_if.load_done) f1_cnt++;
      end
      idle_ports();
      chk("rr_cnt", seq.size(), 32'd4);
      for (int i = 0; i < 4 && i < seq.size(); i++)
         chk($sformatf("rr_seq%0d", i), seq[i], i % 2);
      chk("fp_m0", f0_cnt, 32'd4);
      chk("fp_m1", f1_cnt, 32'd0);
      step();

      // out of window load
      chk("oow_err0", {31'b0, err}, 32'h0);
      m0_if.addr = 32'h1000_0000; m0_if.load = 1'b1;
      step();
      chk("oow_en", {31'b0, mem_en}, 32'h0);
      step();
      chk("oow_done", {31'b0, m0_if.load_done}, 32'h1);
      chk("oow_data", m0_if.data_l, 32'h0);
      chk("oow_err",  {31'b0, err}, 32'h1);
      m0_if.load = 1'b0;
      step();

      // last word inside the window
      m0_if.addr = 32'h0000_3FFC; m0_if.load = 1'b1;
      step();
      chk("edge_en",   {31'b0, mem_en}, 32'h1);
      chk("edge_addr", {20'b0, mem_addr}, 32'hFFF);
      step();
      m0_if.load = 1'b0;
      step();
      chk("err_stky", {31'b0, err}, 32'h1);

      // load and store together: store only
      m0_if.addr = 32'h200; m0_if.data_s = 32'h1111_2222;
      m0_if.select = 4'hF;
      m0_if.load = 1'b1; m0_if.store = 1'b1;
      step();
      chk("ls_we",  {31'b0, mem_we}, 32'h1);
      chk("ls_sd",  {31'b0, m0_if.store_done}, 32'h1);
      chk("ls_ld",  {31'b0, m0_if.load_done}, 32'h0);
      m0_if.load = 1'b0; m0_if.store = 1'b0;
      step();
      chk("ls_ld2", {31'b0, m0_if.load_done}, 32'h0);
      m1_if.addr = 32'h200; m1_if.load = 1'b1;
      step();
      step();
      chk("ls_rd", m1_if.data_l, 32'h1111_2222);
      m1_if.load = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
